// File: rtl/alu_logic_bist_pkg.sv
// Shared ALU definitions: op encoding, width,
// BIST fixed vectors and LFSR helpers.
package alu_logic_bist_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] OP_OR  = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;

  localparam logic [XLEN-1:0] LFSR_MASK =
    64'hD800_0000_0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } vec_t;

  function automatic vec_t fix_vec(
    input logic [1:0] i
  );
    vec_t v;
    unique case (i)
      2'd0: v = '{a: 64'h0123_4567_89AB_CDEF,
                  b: 64'hFEDC_BA98_7654_3210};
      2'd1: v = '{a: 64'hFFFF_FFFF_FFFF_FFFF,
                  b: 64'h0000_0000_0000_0000};
      2'd2: v = '{a: 64'h1234_5678_90AB_CDEF,
                  b: 64'h0F0F_0F0F_0F0F_0F0F};
      default:
            v = '{a: 64'hAAAA_AAAA_AAAA_AAAA,
                  b: 64'h5555_5555_5555_5555};
    endcase
    return v;
  endfunction

  function automatic logic [XLEN-1:0] lfsr_step(
    input logic [XLEN-1:0] s
  );
    return {1'b0, s[XLEN-1:1]} ^
           (s[0] ? LFSR_MASK : '0);
  endfunction

  function automatic logic [XLEN-1:0] rand_b(
    input logic [XLEN-1:0] a
  );
    return ~{a[31:0], a[63:32]};
  endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// 64-bit Galois shift-right LFSR with
// seed reload and advance enable.
module alu_bist_lfsr
  import alu_logic_bist_pkg::*;
#(
  parameter logic [XLEN-1:0] SEED =
    64'hACE1_2468_BDF1_3579
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            adv,
  output logic [XLEN-1:0] state,
  output logic [XLEN-1:0] nxt
);

  assign nxt = lfsr_step(state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (adv) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/alu_logic_bist.sv
// BIST controller for the bitwise ALU units:
// applies vectors, checks results, reports status.
module alu_logic_bist
  import alu_logic_bist_pkg::*;
#(
  parameter int NUM_RAND      = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [XLEN-1:0] LFSR_SEED =
    64'hACE1_2468_BDF1_3579
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clear,
  input  logic [1:0]      op_sel,
  output logic [XLEN-1:0] dut_a,
  output logic [XLEN-1:0] dut_b,
  input  logic [XLEN-1:0] dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      fail_idx,
  output logic [XLEN-1:0] fail_y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] LAST_IDX =
    8'(3 + NUM_RAND);
  localparam logic [15:0] SETTLE_LAST =
    16'(SETTLE_CYCLES - 1);

  logic [1:0]      state;
  logic [1:0]      op_q;
  logic [7:0]      idx;
  logic [7:0]      nidx;
  logic [15:0]     cnt;
  logic [XLEN-1:0] lfsr_q;
  logic [XLEN-1:0] lfsr_nxt;
  logic [XLEN-1:0] exp_y;
  vec_t            nxt_vec;
  logic            go;
  logic            hit;
  logic            lfsr_adv;

  assign go   = ((state == S_IDLE) ||
                 (state == S_DONE)) &&
                start && !clear;
  assign hit  = (dut_y == exp_y);
  assign nidx = idx + 8'd1;
  assign busy = (state == S_APPLY) ||
                (state == S_CHECK);
  assign done = (state == S_DONE);

  // vector 4 uses the seed itself; later ones step first
  assign lfsr_adv = !clear && (state == S_CHECK) &&
                    hit && (idx != LAST_IDX) &&
                    (nidx > 8'd4);

  alu_bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (go),
    .adv   (lfsr_adv),
    .state (lfsr_q),
    .nxt   (lfsr_nxt)
  );

  always_comb begin
    exp_y = '0;
    unique case (op_q)
      OP_OR:   exp_y = dut_a | dut_b;
      OP_AND:  exp_y = dut_a & dut_b;
      OP_XOR:  exp_y = dut_a ^ dut_b;
      default: exp_y = '0;
    endcase
  end

  always_comb begin
    nxt_vec = fix_vec(nidx[1:0]);
    unique case (1'b1)
      (nidx <  8'd4): nxt_vec = fix_vec(nidx[1:0]);
      (nidx == 8'd4): nxt_vec = '{a: lfsr_q,
                                  b: rand_b(lfsr_q)};
      default:        nxt_vec = '{a: lfsr_nxt,
                                  b: rand_b(lfsr_nxt)};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_OR;
      idx      <= '0;
      cnt      <= '0;
      dut_a    <= '0;
      dut_b    <= '0;
      pass     <= 1'b0;
      fail_idx <= '0;
      fail_y   <= '0;
    end else if (clear) begin
      state    <= S_IDLE;
      pass     <= 1'b0;
      fail_idx <= '0;
      fail_y   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q     <= op_sel;
            pass     <= 1'b0;
            fail_idx <= '0;
            fail_y   <= '0;
            if (op_sel == 2'd3) begin
              fail_idx <= 8'hFF;
              state    <= S_DONE;
            end else begin
              idx            <= '0;
              cnt            <= '0;
              {dut_a, dut_b} <= fix_vec(2'd0);
              state          <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (!hit) begin
            fail_idx <= idx;
            fail_y   <= dut_y;
            state    <= S_DONE;
          end else if (idx == LAST_IDX) begin
            pass  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx   <= nidx;
            cnt   <= '0;
            dut_a <= nxt_vec.a;
            dut_b <= nxt_vec.b;
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_logic_bist.sv
// Self-checking bench for alu_logic_bist with a
// fault-injectable bitwise unit model.
module tb_alu_logic_bist;

  localparam int NRAND  = 8;
  localparam int SETTLE = 1;
  localparam int NV     = 4 + NRAND;
  localparam int LIMIT  = 1000;
  localparam logic [63:0] SEED =
    64'hACE1_2468_BDF1_3579;
  localparam logic [63:0] MASK =
    64'hD800_0000_0000_0000;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  unit;
    logic [63:0] stuck;
    int          fidx;
    bit          e_pass;
    int          e_idx;
    int          e_cyc;
  } case_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  op_sel = 2'd0;
  logic [63:0] dut_a;
  logic [63:0] dut_b;
  logic [63:0] dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  fail_idx;
  logic [63:0] fail_y;

  logic [1:0]  unit = 2'd0;
  logic [63:0] stuck = 64'h0;
  int          fidx = -1;

  logic [63:0] va [NV];
  logic [63:0] vb [NV];
  case_t       tbl [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_logic_bist #(
    .NUM_RAND      (NRAND),
    .SETTLE_CYCLES (SETTLE),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .op_sel   (op_sel),
    .dut_a    (dut_a),
    .dut_b    (dut_b),
    .dut_y    (dut_y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_idx (fail_idx),
    .fail_y   (fail_y)
  );

  function automatic logic [63:0] ref_y(
    input logic [1:0] op,
    input logic [63:0] a,
    input logic [63:0] b
  );
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] unit_out(
    input logic [1:0] u,
    input logic [63:0] st,
    input int fx,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [63:0] y;
    y = ref_y(u, a, b) & ~st;
    if (fx >= 0 && fx < NV && a == va[fx])
      y = y ^ 64'h1;
    return y;
  endfunction

  always_comb begin
    dut_y = unit_out(unit, stuck, fidx, dut_a, dut_b);
  end

  task automatic build_vectors();
    logic [63:0] s;
    va[0] = 64'h0123456789ABCDEF; vb[0] = 64'hFEDCBA9876543210;
    va[1] = 64'hFFFFFFFFFFFFFFFF; vb[1] = 64'h0000000000000000;
    va[2] = 64'h1234567890ABCDEF; vb[2] = 64'h0F0F0F0F0F0F0F0F;
    va[3] = 64'hAAAAAAAAAAAAAAAA; vb[3] = 64'h5555555555555555;
    s = SEED;
    for (int k = 0; k < NRAND; k++) begin
      va[4+k] = s;
      vb[4+k] = ~{s[31:0], s[63:32]};
      s = (s >> 1) ^ (s[0] ? MASK : 64'h0);
    end
  endtask

  task automatic model_run(
    input case_t c,
    output bit p,
    output int fi,
    output logic [63:0] fy,
    output int cyc
  );
    logic [63:0] y;
    p = 1'b1; fi = 0; fy = 64'h0;
    cyc = NV * (SETTLE + 1);
    if (c.op == 2'd3) begin
      p = 1'b0; fi = 255; cyc = 0;
      return;
    end
    for (int i = 0; i < NV; i++) begin
      y = unit_out(c.unit, c.stuck, c.fidx, va[i], vb[i]);
      if (y != ref_y(c.op, va[i], vb[i])) begin
        p = 1'b0; fi = i; fy = y;
        cyc = (i + 1) * (SETTLE + 1);
        return;
      end
    end
  endtask

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_case(
    input string tag,
    input case_t c,
    input bit disturb
  );
    bit p;
    int fi;
    int mc;
    int n;
    int busyc;
    int nvec;
    bit vok;
    logic [63:0] fy;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    unit = c.unit; stuck = c.stuck; fidx = c.fidx;
    model_run(c, p, fi, fy, mc);
    @(negedge clk);
    op_sel = c.op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; busyc = 0;
    while (!done && n < LIMIT) begin
      if (busy) begin
        busyc++;
        if (n % (SETTLE + 1) == 0) begin
          qa.push_back(dut_a); qb.push_back(dut_b);
        end
      end
      if (disturb && n == 1) begin
        start = 1'b1; op_sel = 2'd3;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; op_sel = c.op;
    chk({tag, " cycles"}, 64'(n), 64'(c.e_cyc));
    chk({tag, " busy_cycles"}, 64'(busyc), 64'(c.e_cyc));
    chk({tag, " busy_end"}, 64'(busy), 64'h0);
    chk({tag, " pass"}, 64'(pass), 64'(c.e_pass));
    chk({tag, " fail_idx"}, 64'(fail_idx), 64'(c.e_idx));
    chk({tag, " fail_y"}, fail_y, fy);
    if (c.op != 2'd3) begin
      nvec = p ? NV : fi + 1;
      vok = (qa.size() == nvec);
      for (int i = 0; i < qa.size() && i < nvec; i++)
        if (qa[i] !== va[i] || qb[i] !== vb[i]) vok = 1'b0;
      chk({tag, " vectors"}, 64'(vok), 64'h1);
      if (!p) chk({tag, " held_a"}, dut_a, va[fi]);
    end
  endtask

  initial begin
    case_t c;
    bit p;
    int fi;
    int mc;
    logic [63:0] fy;

    build_vectors();
    tbl[0] = '{2'd0, 2'd0, 64'h0,  -1, 1'b1, 0,   24};
    tbl[1] = '{2'd0, 2'd0, 64'h20, -1, 1'b0, 0,   2};
    tbl[2] = '{2'd2, 2'd2, 64'h0,   6, 1'b0, 6,   14};
    tbl[3] = '{2'd1, 2'd1, 64'h0,  -1, 1'b1, 0,   24};
    tbl[4] = '{2'd1, 2'd0, 64'h0,  -1, 1'b0, 0,   2};
    tbl[5] = '{2'd2, 2'd2, 64'h0,  11, 1'b0, 11,  24};
    tbl[6] = '{2'd0, 2'd0, 64'h0,   3, 1'b0, 3,   8};
    tbl[7] = '{2'd3, 2'd0, 64'h0,  -1, 1'b0, 255, 0};

    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst done", 64'(done), 64'h0);
    chk("rst pass", 64'(pass), 64'h0);
    chk("rst fail_idx", 64'(fail_idx), 64'h0);
    chk("rst fail_y", fail_y, 64'h0);
    chk("rst dut_a", dut_a, 64'h0);
    chk("rst dut_b", dut_b, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_case($sformatf("tbl%0d", i), tbl[i], 1'b0);

    // reset in the middle of a run
    @(negedge clk);
    op_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'h0);
    chk("midrst done", 64'(done), 64'h0);
    chk("midrst pass", 64'(pass), 64'h0);
    chk("midrst fail_idx", 64'(fail_idx), 64'h0);
    chk("midrst fail_y", fail_y, 64'h0);
    chk("midrst dut_a", dut_a, 64'h0);
    chk("midrst dut_b", dut_b, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_case("after_rst", tbl[0], 1'b0);

    // start and op change while busy are ignored
    do_case("disturb0", tbl[0], 1'b1);
    do_case("disturb1", tbl[1], 1'b1);

    // clear beats start in DONE
    @(negedge clk);
    clear = 1'b1; start = 1'b1; op_sel = 2'd0;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk("clr done", 64'(done), 64'h0);
    chk("clr busy", 64'(busy), 64'h0);
    chk("clr pass", 64'(pass), 64'h0);
    chk("clr fail_idx", 64'(fail_idx), 64'h0);
    chk("clr fail_y", fail_y, 64'h0);
    chk("clr dut_a", dut_a, va[0]);
    repeat (3) @(negedge clk);
    chk("clr idle busy", 64'(busy), 64'h0);
    chk("clr idle done", 64'(done), 64'h0);

    for (int r = 0; r < 8; r++) begin
      c.op = 2'($urandom_range(0, 2));
      c.unit = c.op;
      c.stuck = ($urandom_range(0, 2) == 0) ?
                (64'h1 << $urandom_range(0, 63)) : 64'h0;
      c.fidx = int'($urandom_range(0, NV));
      if (c.fidx == NV) c.fidx = -1;
      model_run(c, p, fi, fy, mc);
      c.e_pass = p; c.e_idx = fi; c.e_cyc = mc;
      do_case($sformatf("rnd%0d", r), c, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
